// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch front end: default HLT opcode
// and PC step, the queue entry layout at the default 16-bit widths, and the
// helper that sizes occupancy/credit counters.
package fetch_pkg;

    localparam logic [3:0] HLT_OPCODE_DEFAULT = 4'hF;
    localparam int         INSTR_STEP_DEFAULT = 2;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    // A counter that must hold every value from 0 up to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Bundles every handshake/bus signal of the fetch unit: the instruction
// memory request/response channel, the branch redirect input and the
// valid/ready channel towards the IF/ID register.
//   master : the fetch unit (drives requests and the decoupled output)
//   slave  : the surrounding pipeline and instruction memory
interface fetch_queue_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
);
    import fetch_pkg::*;

    localparam int CW = count_width(DEPTH);

    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc_next;
    logic              out_ready;
    logic              fetch_stopped;
    logic [CW-1:0]     occupancy;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr,
               out_pc_next, fetch_stopped, occupancy,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect,
               redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr,
               out_pc_next, fetch_stopped, occupancy,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect,
               redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous WIDTH x DEPTH FIFO with push, pop, clear and an entry count.
// Pushed data is only visible at the head from the following cycle; there is
// no bypass. Clear wins over a simultaneous push. DEPTH must be a power of two.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : discard all entries
//   push/push_data : write one entry (ignored when full unless also popping)
//   pop/pop_data   : remove the head entry (ignored when empty)
//   count, empty   : current fill level
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        pop_data = mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Decoupled instruction-fetch front end. Issues in-order requests to an
// instruction memory of arbitrary latency, buffers returned instructions in a
// DEPTH-entry queue and hands them to IF/ID over valid/ready. A request is
// only issued when a queue slot is guaranteed for its response, so the queue
// cannot overflow. Branch redirects flush the queue and mark every in-flight
// response for discard; an enqueued HLT instruction stops further fetching.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_queue_if master (memory channel, redirect, output channel,
//              fetch_stopped and occupancy status)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INSTR_STEP = INSTR_STEP_DEFAULT,
    parameter logic [3:0]        HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);

    localparam int                CW   = count_width(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     outst;
    logic [CW-1:0]     drop;
    logic              stop;

    logic [CW-1:0]     count;
    logic              fifo_empty;
    entry_t            head;
    entry_t            tail;
    logic [CW:0]       in_use;
    logic              req_valid;
    logic              req_fire;
    logic              rsp_live;
    logic              is_hlt;
    logic              out_valid;
    logic              pop;

    // Credits count both buffered entries and every outstanding request,
    // including those whose responses will be dropped, so a slot is always
    // free when a response arrives. A redirect or HLT suppresses everything
    // that would otherwise issue, enqueue or present in that cycle.
    always_comb begin
        in_use    = {1'b0, count} + {1'b0, outst};
        req_valid = ~rst & ~bus.redirect & ~stop & (in_use < (CW+1)'(DEPTH));
        req_fire  = req_valid & bus.imem_req_ready;
        rsp_live  = bus.imem_rsp_valid & ~bus.redirect & ~stop & (drop == '0);
        is_hlt    = (bus.imem_rsp_data[DATA_W-1 -: 4] == HLT_OPCODE);
        out_valid = ~rst & ~fifo_empty & ~bus.redirect;
        pop       = out_valid & bus.out_ready;
        tail.pc    = rsp_pc;
        tail.instr = bus.imem_rsp_data;
    end

    always_comb begin
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = fetch_pc;
        bus.out_valid      = out_valid;
        bus.out_instr      = head.instr;
        bus.out_pc_next    = head.pc + STEP;
        bus.fetch_stopped  = stop;
        bus.occupancy      = count;
    end

    // PC, credit and drop bookkeeping. On a redirect no request can issue, so
    // whatever is still outstanding after this cycle's response (which is
    // itself discarded) is exactly what must be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            outst    <= '0;
            drop     <= '0;
            stop     <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            rsp_pc   <= bus.redirect_pc;
            stop     <= 1'b0;
            outst    <= outst - CW'(bus.imem_rsp_valid);
            drop     <= outst - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            outst <= outst + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
            if (rsp_live) begin
                rsp_pc <= rsp_pc + STEP;
                if (is_hlt) stop <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.redirect),
        .push      (rsp_live),
        .push_data (tail),
        .pop       (pop),
        .pop_data  (head),
        .count     (count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed bench for fetch_queue with DEPTH = 4. A behavioural instruction
// memory with configurable latency answers requests; every response that
// should survive (not issued before a redirect, not after an HLT) is pushed
// to a scoreboard and popped when the DUT hands an instruction to IF/ID.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          epoch;
        int          due;
    } mem_req_t;

    logic clk = 1'b0;
    logic rst;

    fetch_queue_if #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH)) bus();

    fetch_queue #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .INSTR_STEP (2),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    fetch_entry_t sb[$];
    mem_req_t     pend[$];
    int           n_checks   = 0;
    int           n_fail     = 0;
    int           cyc        = 0;
    int           epoch      = 0;
    int           lat        = 1;
    logic         mstop      = 1'b0;
    logic [15:0]  exp_pc     = RESET_PC;
    logic         hlt_en     = 1'b0;
    logic [15:0]  hlt_addr   = 16'h0000;
    logic         rand_ready = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] memData(input logic [15:0] addr);
        if (hlt_en && addr == hlt_addr) return 16'hF000 | (addr >> 1);
        return 16'h1000 + (addr >> 1);
    endfunction

    // One clock cycle: check outputs at the falling edge, update the model
    // with what the rising edge will commit, then drive the memory response.
    task automatic applyStimulus();
        fetch_entry_t e;
        mem_req_t     m;
        logic         exp_req;
        @(negedge clk);
        if (rst) begin
            checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            pend.delete();
            sb.delete();
            mstop  = 1'b0;
            exp_pc = RESET_PC;
            epoch++;
        end else begin
            exp_req = !bus.redirect && !mstop && (sb.size() + pend.size() < DEPTH);
            checkOutput("occupancy", 32'(bus.occupancy), 32'(sb.size()));
            checkOutput("out_valid", 32'(bus.out_valid), 32'((sb.size() != 0) && !bus.redirect));
            checkOutput("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            checkOutput("fetch_stopped", 32'(bus.fetch_stopped), 32'(mstop));
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("out_instr", 32'(bus.out_instr), 32'(e.instr));
                checkOutput("out_pc_next", 32'(bus.out_pc_next), 32'(e.pc + 16'd2));
            end
            if (bus.imem_rsp_valid && pend.size() > 0) begin
                m = pend.pop_front();
                if (!bus.redirect && m.epoch == epoch && !mstop) begin
                    e.pc    = m.addr;
                    e.instr = m.data;
                    sb.push_back(e);
                    if (m.data[15:12] == 4'hF) mstop = 1'b1;
                end
            end
            if (bus.redirect) begin
                sb.delete();
                mstop  = 1'b0;
                exp_pc = bus.redirect_pc;
                epoch++;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                checkOutput("req_addr", 32'(bus.imem_req_addr), 32'(exp_pc));
                m.addr  = bus.imem_req_addr;
                m.data  = memData(bus.imem_req_addr);
                m.epoch = epoch;
                m.due   = cyc + lat;
                pend.push_back(m);
                exp_pc  = exp_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = pend[0].data;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 16'h0000;
        end
        if (rand_ready) bus.imem_req_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.out_ready      = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 16'h0000;
        repeat (2) applyStimulus();

        // Streaming with a 1-cycle memory: request at 0, response at 1, output at 2.
        rst = 1'b0;
        #1;
        checkOutput("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("first_req_addr", 32'(bus.imem_req_addr), 32'(RESET_PC));
        checkOutput("c0_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("c0_occupancy", 32'(bus.occupancy), 32'd0);
        applyStimulus();
        checkOutput("c1_out_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus();
        checkOutput("c2_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("c2_out_instr", 32'(bus.out_instr), 32'h1000);
        checkOutput("c2_out_pc_next", 32'(bus.out_pc_next), 32'h0002);
        repeat (6) applyStimulus();

        // Back-pressure: issue stops once the queue plus in-flight fill DEPTH.
        bus.out_ready = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("stall_occupancy", 32'(bus.occupancy), 32'd4);
        checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.out_ready = 1'b1;
        repeat (8) applyStimulus();

        // 3-cycle memory, redirect with responses in flight.
        lat = 3;
        repeat (10) applyStimulus();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        applyStimulus();
        bus.redirect = 1'b0;
        #1;
        checkOutput("redir_occupancy", 32'(bus.occupancy), 32'd0);
        for (int i = 0; i < 20 && !bus.out_valid; i++) applyStimulus();
        checkOutput("redir_head_pc_next", 32'(bus.out_pc_next), 32'h0042);
        checkOutput("redir_head_instr", 32'(bus.out_instr), 32'h1020);
        repeat (6) applyStimulus();

        // HLT at PC 8 with later requests still in flight.
        hlt_en          = 1'b1;
        hlt_addr        = 16'h0008;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0000;
        applyStimulus();
        bus.redirect = 1'b0;
        repeat (25) applyStimulus();
        checkOutput("hlt_stopped", 32'(bus.fetch_stopped), 32'd1);
        checkOutput("hlt_no_req", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("hlt_drained", 32'(bus.occupancy), 32'd0);
        hlt_en          = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        applyStimulus();
        bus.redirect = 1'b0;
        repeat (8) applyStimulus();

        // Redirect coinciding with a response and an output handshake.
        lat = 1;
        repeat (6) applyStimulus();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        #1;
        checkOutput("redir_same_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("redir_same_req_valid", 32'(bus.imem_req_valid), 32'd0);
        applyStimulus();
        bus.redirect = 1'b0;
        repeat (8) applyStimulus();

        // Memory that randomly refuses requests.
        rand_ready = 1'b1;
        repeat (20) applyStimulus();
        rand_ready         = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (4) applyStimulus();

        // Reset with a full queue.
        bus.out_ready = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("pre_rst_occupancy", 32'(bus.occupancy), 32'd4);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_occupancy", 32'(bus.occupancy), 32'd0);
        checkOutput("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("post_rst_req_addr", 32'(bus.imem_req_addr), 32'(RESET_PC));
        bus.out_ready = 1'b1;
        repeat (8) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined CPU: replaces the single-cycle PC register and instruction memory read in IF with a decoupled fetch unit. It issues in-order requests to an instruction memory of arbitrary latency and buffers returned instructions in a DEPTH-entry queue. It presents them to the IF/ID register with a valid/ready handshake, and handles branch redirects (flush of queued and in-flight fetches) and HLT detection.

## Interface
- DATA_W, 16, instruction width.
- ADDR_W, 16, PC / memory address width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.
- INSTR_STEP, 2, PC increment per instruction.
- HLT_OPCODE, 4'hF, value of instr[DATA_W-1:DATA_W-4] that stops fetch.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  ADDR_W  request address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  in  DATA_W  fetched instruction.
- redirect  in  1  branch taken in EX; discard everything, restart at redirect_pc.
- redirect_pc  in  ADDR_W  branch target.
- out_valid  out  1  queue head valid.
- out_instr  out  DATA_W  head instruction.
- out_pc_next  out  ADDR_W  head PC + INSTR_STEP (feeds PCS / branch base).
- out_ready  in  1  IF/ID accepts head (= ~stall).
- fetch_stopped  out  1  HLT enqueued; no further requests issued.
- occupancy  out  $clog2(DEPTH+1)  queue entry count.

## Operation
- State: fetch_pc (next request address), rsp_pc (PC of next live response), queue, total outstanding counter `outst`, drop counter `drop`, stop flag.
- Issue: imem_req_valid = ~rst & ~redirect & ~stop & (occupancy + outst < DEPTH). On handshake: fetch_pc += INSTR_STEP, outst += 1.
- Response: outst -= 1. If drop > 0: drop -= 1, data discarded. Otherwise enqueue {rsp_pc, data}, rsp_pc += INSTR_STEP; the credit rule guarantees that the queue never overflows.
- HLT: a live response with HLT opcode is enqueued and sets stop. Later live responses, from requests already in flight, are discarded. stop holds until redirect or rst.
- Dequeue: on out_valid & out_ready the head is popped. out_pc_next = head pc + INSTR_STEP, modulo 2^ADDR_W.
- Redirect, which has priority over every other event in the same cycle:
  - Queue cleared, stop cleared, fetch_pc and rsp_pc set to redirect_pc.
  - drop set to outst − imem_rsp_valid. Any response arriving in this cycle is discarded.
  - out_valid and imem_req_valid are forced to 0 in the cycle.
- Counters: outst and drop never exceed DEPTH. PC arithmetic wraps silently.

## Timing
- Reset values: fetch_pc = rsp_pc = RESET_PC; queue empty; outst = drop = 0; stop = 0.
- Output reset values: imem_req_valid = 0 during the rst cycle; out_valid = 0; fetch_stopped = 0; occupancy = 0.
- First request is issued in the cycle after rst deasserts.
- Latency: request accepted at t with 1-cycle memory → response at t+1 → out_valid at t+2. No bypass from response to output.
- Throughput: one instruction per cycle when memory latency L ≤ DEPTH−1.
- Same-cycle enqueue and dequeue on a full queue is legal; occupancy is unchanged.
- Same-cycle response and issue: outst is unchanged.
- rst mid-operation: all state returns to reset values at that edge. Memory responses still due after reset are the memory's responsibility; the memory is reset together with the fetch unit.
- Redirect at t: first request to redirect_pc is issued at t+1, or later if credits are exhausted.

## Structure
- Package `fetch_pkg`: HLT_OPCODE default, INSTR_STEP default, the typedef for a queue entry {pc, instr}, and a clog2-based count-width function.
- Sub-module `fetch_fifo`: synchronous FIFO of WIDTH × DEPTH with push/pop/clear and count, with no bypass. Clear has priority over push.
- Credit, drop and PC logic live in fetch_queue.

## Test plan
- Reset then 1-cycle memory returning 16'h1000, 16'h1001, … with out_ready = 1.
  - Requests to 0, 2, 4, … one per cycle.
  - Outputs appear from cycle 2, in order, with out_pc_next = 2, 4, 6.
- out_ready = 0 for 10 cycles with DEPTH = 4.
  - Issuing stops once occupancy + outst = 4; occupancy = 4.
  - No instruction is lost or duplicated after out_ready returns.
- 3-cycle memory latency with 3 requests in flight, then redirect to 16'h0040.
  - The 3 in-flight responses are dropped; queue is empty.
  - Next output has pc 16'h0040 (out_pc_next = 16'h0042).
- Response carrying opcode 4'hF at PC 8 with 2 more requests in flight.
  - HLT is enqueued and fetch_stopped = 1; the 2 following responses are discarded.
  - No further imem_req_valid until a redirect.
- Redirect in the same cycle as imem_rsp_valid and out_valid & out_ready.
  - Response is discarded; drop = outst − 1.
  - out_valid = 0 that cycle; no stale instruction is ever output.
- rst asserted mid-stream with a full queue.
  - Next cycle: occupancy = 0, out_valid = 0, request to RESET_PC issued.
